bomb_controller: RTL and testbench

BOMB_CONTROLLER -- requirements
Module: bomb_controller

---
 rtl/bomberman_pkg.sv | 45 ++++
 rtl/bomb_pixel_gen.sv | 30 +++
 rtl/bomb_controller.sv | 134 +++++++++++++
 tb/tb_bomb_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// Shared tile geometry, FSM state encoding, layer colours and tile helpers for the bomb logic.
package bomberman_pkg;

    localparam int unsigned TILE_SIZE  = 16;
    localparam int unsigned TILE_SHIFT = 4;
    localparam int unsigned GRID_W     = 40;
    localparam int unsigned GRID_H     = 30;
    localparam int unsigned TILE_W     = 7;
    localparam int unsigned PIX_W      = 10;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t ARMED   = 2'd1;
    localparam state_t EXPLODE = 2'd2;

    localparam logic [11:0] BOMB_RGB      = 12'h222;
    localparam logic [11:0] EXPLOSION_RGB = 12'hF80;

    // Tile under a raw pixel coordinate.
    function automatic logic [TILE_W-1:0] pix_tile(input logic [PIX_W-1:0] p);
        pix_tile = TILE_W'(p >> TILE_SHIFT);
    endfunction

    // Tile under a sprite's centre, given its top-left pixel.
    function automatic logic [TILE_W-1:0] pos_tile(input logic [PIX_W-1:0] p);
        pos_tile = TILE_W'(((PIX_W+1)'(p) + (PIX_W+1)'(TILE_SIZE / 2)) >> TILE_SHIFT);
    endfunction

    // Plus-shaped blast; absolute distances never wrap, and off-grid tiles never hit.
    function automatic logic in_blast(input logic [TILE_W-1:0] px,
                                      input logic [TILE_W-1:0] py,
                                      input logic [TILE_W-1:0] tx,
                                      input logic [TILE_W-1:0] ty,
                                      input int unsigned       arm);
        logic [TILE_W-1:0] dx;
        logic [TILE_W-1:0] dy;
        dx = (px >= tx) ? (px - tx) : (tx - px);
        dy = (py >= ty) ? (py - ty) : (ty - py);
        in_blast = (px < TILE_W'(GRID_W)) && (py < TILE_W'(GRID_H)) &&
                   (((px == tx) && (dy <= TILE_W'(arm))) ||
                    ((py == ty) && (dx <= TILE_W'(arm))));
    endfunction

endpackage

// File: rtl/bomb_pixel_gen.sv
// Stateless pixel/body hit tests against the armed bomb tile and its blast.
module bomb_pixel_gen
    import bomberman_pkg::*;
#(
    parameter int unsigned BLAST_RANGE = 2
) (
    input  logic              armed,
    input  logic              explode,
    input  logic [TILE_W-1:0] tx,
    input  logic [TILE_W-1:0] ty,
    input  logic [TILE_W-1:0] b_tx,
    input  logic [TILE_W-1:0] b_ty,
    input  logic [PIX_W-1:0]  v_x,
    input  logic [PIX_W-1:0]  v_y,
    output logic              bomb_on,
    output logic              explosion_on,
    output logic              body_hit
);

    logic [TILE_W-1:0] px;
    logic [TILE_W-1:0] py;

    assign px = pix_tile(v_x);
    assign py = pix_tile(v_y);

    assign bomb_on      = armed && (px == tx) && (py == ty);
    assign explosion_on = explode && in_blast(px, py, tx, ty, BLAST_RANGE);
    assign body_hit     = explode && in_blast(b_tx, b_ty, tx, ty, BLAST_RANGE);

endmodule

// File: rtl/bomb_controller.sv
// Single-bomb fuse/blast FSM with sticky game_over.
// Define REMOTE_DETONATE_EN to let a place edge during ARMED detonate immediately.
module bomb_controller
    import bomberman_pkg::*;
#(
    parameter int unsigned FUSE_CYCLES  = 200_000_000,
    parameter int unsigned BLAST_CYCLES = 50_000_000,
    parameter int unsigned BLAST_RANGE  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        place,
    input  logic [9:0]  b_x,
    input  logic [9:0]  b_y,
    input  logic [9:0]  v_x,
    input  logic [9:0]  v_y,
    output logic        bomb_on,
    output logic        explosion_on,
    output logic [11:0] bomb_rgb,
    output logic [11:0] explosion_rgb,
    output logic        bomb_active,
    output logic        game_over
);

    localparam int unsigned CNT_MAX = (FUSE_CYCLES > BLAST_CYCLES) ? FUSE_CYCLES : BLAST_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FUSE_LOAD  = CNT_W'(FUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLAST_LOAD = CNT_W'(BLAST_CYCLES - 1);

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [TILE_W-1:0] tx;
    logic [TILE_W-1:0] ty;
    logic [TILE_W-1:0] tx_n;
    logic [TILE_W-1:0] ty_n;
    logic [TILE_W-1:0] b_tx;
    logic [TILE_W-1:0] b_ty;
    logic              place_q;
    logic              rise;
    logic              go_q;
    logic              go_n;
    logic              body_hit;

    assign rise = place & ~place_q;
    assign b_tx = pos_tile(b_x);
    assign b_ty = pos_tile(b_y);

    // Counter holds (remaining cycles - 1) and is reloaded on every state entry.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tx_n    = tx;
        ty_n    = ty;
        go_n    = go_q | body_hit;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = ARMED;
                    cnt_n   = FUSE_LOAD;
                    tx_n    = b_tx;
                    ty_n    = b_ty;
                end
            end
            ARMED: begin
`ifdef REMOTE_DETONATE_EN
                if (rise || (cnt == '0)) begin
`else
                if (cnt == '0) begin
`endif
                    state_n = EXPLODE;
                    cnt_n   = BLAST_LOAD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            EXPLODE: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // place_q resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            tx      <= '0;
            ty      <= '0;
            place_q <= 1'b1;
            go_q    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            tx      <= tx_n;
            ty      <= ty_n;
            place_q <= place;
            go_q    <= go_n;
        end
    end

    bomb_pixel_gen #(
        .BLAST_RANGE (BLAST_RANGE)
    ) u_pixel_gen (
        .armed        (state == ARMED),
        .explode      (state == EXPLODE),
        .tx           (tx),
        .ty           (ty),
        .b_tx         (b_tx),
        .b_ty         (b_ty),
        .v_x          (v_x),
        .v_y          (v_y),
        .bomb_on      (bomb_on),
        .explosion_on (explosion_on),
        .body_hit     (body_hit)
    );

    assign bomb_active   = (state != IDLE);
    assign game_over     = go_q | body_hit;
    assign bomb_rgb      = BOMB_RGB;
    assign explosion_rgb = EXPLOSION_RGB;

endmodule

// File: tb/tb_bomb_controller.sv
// Self-checking bench for bomb_controller with FUSE_CYCLES=10, BLAST_CYCLES=5, BLAST_RANGE=2.
module tb_bomb_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        place;
    logic [9:0]  b_x;
    logic [9:0]  b_y;
    logic [9:0]  v_x;
    logic [9:0]  v_y;
    logic        bomb_on;
    logic        explosion_on;
    logic [11:0] bomb_rgb;
    logic [11:0] explosion_rgb;
    logic        bomb_active;
    logic        game_over;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic active;
        logic bomb;
        logic expl;
        logic go;
    } obs_t;

    typedef struct {
        logic [9:0] vx;
        logic [9:0] vy;
        logic       bomb;
        logic       expl;
    } vec_t;

    obs_t exp_q[$];
    vec_t tbl[15];

    bomb_controller #(
        .FUSE_CYCLES  (10),
        .BLAST_CYCLES (5),
        .BLAST_RANGE  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .place         (place),
        .b_x           (b_x),
        .b_y           (b_y),
        .v_x           (v_x),
        .v_y           (v_y),
        .bomb_on       (bomb_on),
        .explosion_on  (explosion_on),
        .bomb_rgb      (bomb_rgb),
        .explosion_rgb (explosion_rgb),
        .bomb_active   (bomb_active),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_obs(input logic a, input logic b, input logic e, input logic g);
        obs_t o;
        o = {a, b, e, g};
        exp_q.push_back(o);
    endtask

    // Pop the oldest expectation and compare it with the DUT away from the clock edge.
    task automatic sample(input string name);
        obs_t o;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            o = exp_q.pop_front();
            chk({name, ".active"},    32'(bomb_active),  32'(o.active));
            chk({name, ".bomb_on"},   32'(bomb_on),      32'(o.bomb));
            chk({name, ".expl_on"},   32'(explosion_on), 32'(o.expl));
            chk({name, ".game_over"}, 32'(game_over),    32'(o.go));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Follows a bomb placed in the previous cycle; viewer pixel is expected on the bomb tile.
    task automatic watch(input int a_n, input int e_n, input int i_n, input int go_from,
                         input int press_at, input logic [9:0] nbx, input logic [9:0] nby,
                         input string name);
        for (int k = 1; k <= a_n + e_n + i_n; k++) begin
            tick();
            place = (k == press_at);
            if (k == 1) begin
                b_x = nbx;
                b_y = nby;
            end
            expect_obs(k <= a_n + e_n, k <= a_n, (k > a_n) && (k <= a_n + e_n),
                       (go_from > 0) && (k >= go_from));
            sample(name);
        end
        place = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{10'd0,   10'd0,   1'b1, 1'b0};
        tbl[1]  = '{10'd15,  10'd15,  1'b1, 1'b0};
        tbl[2]  = '{10'd16,  10'd0,   1'b0, 1'b0};
        tbl[3]  = '{10'd0,   10'd16,  1'b0, 1'b0};
        tbl[4]  = '{10'd624, 10'd0,   1'b0, 1'b0};
        tbl[5]  = '{10'd0,   10'd464, 1'b0, 1'b0};
        tbl[6]  = '{10'd32,  10'd0,   1'b0, 1'b0};
        tbl[7]  = '{10'd8,   10'd8,   1'b1, 1'b0};
        tbl[8]  = '{10'd0,   10'd0,   1'b1, 1'b0};
        tbl[9]  = '{10'd0,   10'd0,   1'b1, 1'b0};
        tbl[10] = '{10'd32,  10'd0,   1'b0, 1'b1};
        tbl[11] = '{10'd0,   10'd32,  1'b0, 1'b1};
        tbl[12] = '{10'd48,  10'd0,   1'b0, 1'b0};
        tbl[13] = '{10'd624, 10'd0,   1'b0, 1'b0};
        tbl[14] = '{10'd0,   10'd464, 1'b0, 1'b0};

        reset = 1'b1;
        place = 1'b0;
        b_x   = 10'd100;
        b_y   = 10'd60;
        v_x   = 10'd100;
        v_y   = 10'd70;
        tick();
        tick();
        expect_obs(1'b0, 1'b0, 1'b0, 1'b0);
        sample("reset");
        chk("bomb_rgb", 32'(bomb_rgb), 32'h222);
        chk("explosion_rgb", 32'(explosion_rgb), 32'hF80);
        reset = 1'b0;

        // Basic fuse/blast timing; bomberman stands on the bomb and is hit.
        tick();
        place = 1'b1;
        watch(10, 5, 2, 11, 0, 10'd100, 10'd60, "timing");
        do_reset();

        // Second press while armed; bomberman walks away, tile must not follow.
        tick();
        place = 1'b1;
`ifdef REMOTE_DETONATE_EN
        watch(3, 5, 2, 0, 3, 10'd300, 10'd300, "repress");
`else
        watch(10, 5, 2, 0, 3, 10'd300, 10'd300, "repress");
`endif
        do_reset();

        b_x = 10'd100;
        b_y = 10'd60;
        tick();
        place = 1'b1;
        watch(10, 5, 1, 11, 0, 10'd128, 10'd60, "hit_8_4");
        do_reset();

        b_x = 10'd100;
        b_y = 10'd60;
        tick();
        place = 1'b1;
        watch(10, 5, 1, 0, 0, 10'd144, 10'd60, "miss_9_4");
        do_reset();

        // Corner bomb at tile (0,0): pixel table across ARMED then EXPLODE.
        b_x = 10'd0;
        b_y = 10'd0;
        tick();
        place = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            place = 1'b0;
            if (k == 1) begin
                b_x = 10'd600;
                b_y = 10'd400;
            end
            v_x = tbl[k-1].vx;
            v_y = tbl[k-1].vy;
            expect_obs(1'b1, tbl[k-1].bomb, tbl[k-1].expl, 1'b0);
            sample($sformatf("corner[%0d]", k - 1));
        end
        tick();
        v_x = 10'd0;
        v_y = 10'd0;
        expect_obs(1'b0, 1'b0, 1'b0, 1'b0);
        sample("corner_idle");
        do_reset();

        // Reset three cycles into EXPLODE.
        b_x = 10'd100;
        b_y = 10'd60;
        v_x = 10'd100;
        v_y = 10'd70;
        tick();
        place = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            place = 1'b0;
            expect_obs(1'b1, k <= 10, k > 10, k >= 11);
            sample("pre_abort");
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_obs(1'b0, 1'b0, 1'b0, 1'b0);
        sample("abort_explode");

        // Reset mid-ARMED: the bomb must never go off.
        tick();
        place = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            place = 1'b0;
            expect_obs(1'b1, 1'b1, 1'b0, 1'b0);
            sample("pre_abort_armed");
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            expect_obs(1'b0, 1'b0, 1'b0, 1'b0);
            sample("abort_armed");
        end

        // Button held through reset release places nothing; a fresh press does.
        place = 1'b1;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            tick();
            expect_obs(1'b0, 1'b0, 1'b0, 1'b0);
            sample("held_reset");
        end
        tick();
        place = 1'b0;
        tick();
        place = 1'b1;
        tick();
        place = 1'b0;
        expect_obs(1'b1, 1'b1, 1'b0, 1'b0);
        sample("repress_after_reset");
        do_reset();

        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
